ps2_key_receiver: RTL

Parametrised PS/2 keyboard receiver running in the clock27 domain. It synchronises and deglitches the PS/2 clock and data lines, deframes 11-bit frames and checks start, odd parity and stop bits. It tracks F0 (break) and E0 (extended) prefixes, translates scancodes to the team's letter/number/enter codes, and buffers decoded key events in a FIFO with a valid/ready handshake for downstream game logic.

---
 rtl/ps2_key_receiver.sv | 257 +++++++++++++++++++++++++
 1 files changed

// File: rtl/ps2_key_receiver.sv
// PS/2 keyboard receiver: sync/deglitch, 11-bit deframing, F0/E0 prefix tracking, scancode translation.
// An event reaches keyValid 2 cycles after the stop-bit fall; a full FIFO drops new events and sets sticky overflow.
module ps2_key_receiver #(
  parameter int SYNC_STAGES    = 2,
  parameter int FILTER_LEN     = 4,
  parameter int TIMEOUT_CYCLES = 27000,
  parameter int FIFO_DEPTH     = 8
) (
  input  logic                          clock27,
  input  logic                          resetN,
  input  logic                          keyboardClock,
  input  logic                          keyboardData,
  input  logic                          keyReady,
  input  logic                          clearOverflow,
  output logic                          keyValid,
  output logic [7:0]                    keyCode,
  output logic                          keyBreak,
  output logic                          keyExtended,
  output logic [1:0]                    keyClass,
  output logic [6:0]                    keyValue,
  output logic [$clog2(FIFO_DEPTH):0]   fifoCount,
  output logic                          overflow,
  output logic                          frameError,
  output logic [7:0]                    parityErrCount,
  output logic                          busy
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [FW-1:0] FILT_MAX = FW'(FILTER_LEN - 1);
  localparam logic [TW-1:0] TMO_MAX  = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [AW:0]   DEPTH    = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  typedef struct packed {
    logic [7:0] code;
    logic       brk;
    logic       ext;
    logic [1:0] cls;
    logic [6:0] val;
  } ev_t;

  function automatic logic [8:0] translate(input logic [7:0] c);
    logic [8:0] r;
    r = {2'b00, 7'd88};
    if (c >= 8'h15 && c <= 8'h4D) r = {2'b00, 7'd99};
    case (c)
      8'h1C: r = {2'b01, 7'd0};
      8'h32: r = {2'b01, 7'd1};
      8'h21: r = {2'b01, 7'd2};
      8'h23: r = {2'b01, 7'd3};
      8'h24: r = {2'b01, 7'd4};
      8'h2B: r = {2'b01, 7'd5};
      8'h34: r = {2'b01, 7'd6};
      8'h33: r = {2'b01, 7'd7};
      8'h43: r = {2'b01, 7'd8};
      8'h3B: r = {2'b01, 7'd9};
      8'h45: r = {2'b10, 7'd0};
      8'h16: r = {2'b10, 7'd1};
      8'h1E: r = {2'b10, 7'd2};
      8'h26: r = {2'b10, 7'd3};
      8'h25: r = {2'b10, 7'd4};
      8'h2E: r = {2'b10, 7'd5};
      8'h36: r = {2'b10, 7'd6};
      8'h3D: r = {2'b10, 7'd7};
      8'h3E: r = {2'b10, 7'd8};
      8'h46: r = {2'b10, 7'd9};
      8'h5A: r = {2'b11, 7'd55};
      default: ;
    endcase
    return r;
  endfunction

  logic [SYNC_STAGES-1:0] kclk_sync_q, kclk_sync_d, kdat_sync_q, kdat_sync_d;
  logic                   filt_q, filt_d, fall_q, fall_d;
  logic [FW-1:0]          fcnt_q, fcnt_d;
  logic                   clk_s, dat_s;

  state_t                 state_q, state_d;
  logic [7:0]             sh_q, sh_d;
  logic [2:0]             bit_q, bit_d;
  logic                   par_q, par_d;
  logic                   brk_q, brk_d, ext_q, ext_d;
  logic [TW-1:0]          tmr_q, tmr_d;
  logic                   push_q, push_d, fe_q, fe_d;
  ev_t                    ev_q, ev_d;
  logic [7:0]             pcnt_q, pcnt_d;
  logic                   timeout;

  ev_t                    mem_q [FIFO_DEPTH];
  ev_t                    mem_d [FIFO_DEPTH];
  logic [AW-1:0]          wr_q, wr_d, rd_q, rd_d;
  logic [AW:0]            cnt_q, cnt_d;
  logic                   ovf_q, ovf_d;
  logic                   pop, full, wr_en, drop;
  ev_t                    head;

  assign clk_s = kclk_sync_q[SYNC_STAGES-1];
  assign dat_s = kdat_sync_q[SYNC_STAGES-1];

  // Filtered clock only follows the synced line after FILTER_LEN samples disagree in a row.
  always_comb begin
    kclk_sync_d = {kclk_sync_q[SYNC_STAGES-2:0], keyboardClock};
    kdat_sync_d = {kdat_sync_q[SYNC_STAGES-2:0], keyboardData};
    filt_d      = filt_q;
    fcnt_d      = '0;
    if (clk_s != filt_q) begin
      if (fcnt_q == FILT_MAX) filt_d = clk_s;
      else                    fcnt_d = fcnt_q + 1'b1;
    end
    fall_d = filt_q & ~filt_d;
  end

  always_comb begin
    state_d = state_q;
    sh_d    = sh_q;
    bit_d   = bit_q;
    par_d   = par_q;
    brk_d   = brk_q;
    ext_d   = ext_q;
    push_d  = 1'b0;
    ev_d    = ev_q;
    fe_d    = 1'b0;
    pcnt_d  = pcnt_q;
    tmr_d   = (state_q == IDLE || fall_q) ? '0 : tmr_q + 1'b1;
    timeout = (state_q != IDLE) && !fall_q && (tmr_q == TMO_MAX);
    case (state_q)
      IDLE: if (fall_q && !dat_s) begin
        state_d = DATA;
        bit_d   = '0;
      end
      DATA: if (fall_q) begin
        sh_d  = {dat_s, sh_q[7:1]};
        bit_d = bit_q + 1'b1;
        if (bit_q == 3'd7) state_d = PARITY;
      end
      PARITY: if (fall_q) begin
        par_d   = dat_s;
        state_d = STOP;
      end
      STOP: if (fall_q) begin
        state_d = IDLE;
        if (!dat_s) begin
          fe_d = 1'b1;
        end else if ((^sh_q ^ par_q) != 1'b1) begin
          if (pcnt_q != 8'hFF) pcnt_d = pcnt_q + 1'b1;
          brk_d = 1'b0;
          ext_d = 1'b0;
        end else if (sh_q == 8'hF0) begin
          brk_d = 1'b1;
        end else if (sh_q == 8'hE0) begin
          ext_d = 1'b1;
        end else begin
          push_d             = 1'b1;
          ev_d.code          = sh_q;
          ev_d.brk           = brk_q;
          ev_d.ext           = ext_q;
          {ev_d.cls, ev_d.val} = translate(sh_q);
          brk_d              = 1'b0;
          ext_d              = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
    // Timeout abandons the frame but keeps any pending prefix.
    if (timeout) begin
      state_d = IDLE;
      fe_d    = 1'b1;
      tmr_d   = '0;
    end
  end

  always_comb begin
    pop   = keyValid & keyReady;
    full  = (cnt_q == DEPTH);
    wr_en = push_q & (~full | pop);
    drop  = push_q & full & ~pop;
    mem_d = mem_q;
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (wr_en) begin
      mem_d[wr_q] = ev_q;
      wr_d        = wr_q + 1'b1;
    end
    if (pop) rd_d = rd_q + 1'b1;
    if (wr_en && !pop)      cnt_d = cnt_q + 1'b1;
    else if (!wr_en && pop) cnt_d = cnt_q - 1'b1;
    ovf_d = ovf_q;
    if (clearOverflow) ovf_d = 1'b0;
    if (drop)          ovf_d = 1'b1;
  end

  always_ff @(posedge clock27 or negedge resetN) begin
    if (!resetN) begin
      kclk_sync_q <= '1;
      kdat_sync_q <= '1;
      filt_q      <= 1'b1;
      fcnt_q      <= '0;
      fall_q      <= 1'b0;
      state_q     <= IDLE;
      sh_q        <= '0;
      bit_q       <= '0;
      par_q       <= 1'b0;
      brk_q       <= 1'b0;
      ext_q       <= 1'b0;
      tmr_q       <= '0;
      push_q      <= 1'b0;
      ev_q        <= '0;
      fe_q        <= 1'b0;
      pcnt_q      <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      wr_q        <= '0;
      rd_q        <= '0;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
    end else begin
      kclk_sync_q <= kclk_sync_d;
      kdat_sync_q <= kdat_sync_d;
      filt_q      <= filt_d;
      fcnt_q      <= fcnt_d;
      fall_q      <= fall_d;
      state_q     <= state_d;
      sh_q        <= sh_d;
      bit_q       <= bit_d;
      par_q       <= par_d;
      brk_q       <= brk_d;
      ext_q       <= ext_d;
      tmr_q       <= tmr_d;
      push_q      <= push_d;
      ev_q        <= ev_d;
      fe_q        <= fe_d;
      pcnt_q      <= pcnt_d;
      mem_q       <= mem_d;
      wr_q        <= wr_d;
      rd_q        <= rd_d;
      cnt_q       <= cnt_d;
      ovf_q       <= ovf_d;
    end
  end

  assign head           = mem_q[rd_q];
  assign keyValid       = (cnt_q != '0);
  assign keyCode        = keyValid ? head.code : '0;
  assign keyBreak       = keyValid & head.brk;
  assign keyExtended    = keyValid & head.ext;
  assign keyClass       = keyValid ? head.cls : '0;
  assign keyValue       = keyValid ? head.val : '0;
  assign fifoCount      = cnt_q;
  assign overflow       = ovf_q;
  assign frameError     = fe_q;
  assign parityErrCount = pcnt_q;
  assign busy           = (state_q != IDLE);

endmodule
